// File: rtl/muxn_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : muxn_scan_if
// Description : Bundle between a bank of W-bit channel sources and the
//               registered N-to-1 scanning multiplexer.
//               master : drives d, s, mode, en (and mask), observes outputs
//               slave  : the multiplexer itself
//               Optional macro: MUXN_SCAN_MASK_EN adds the mask signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface muxn_scan_if #(
  parameter int W = 4,
  parameter int N = 4
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] d;      // flattened channels, channel k = d[k*W +: W]
  logic [SW-1:0]  s;      // direct-mode select
  logic           mode;   // 0 = direct, 1 = auto-scan
  logic           en;     // sample enable
`ifdef MUXN_SCAN_MASK_EN
  logic [N-1:0]   mask;   // scan channel enable
`endif
  logic [W-1:0]   y;      // registered selected data
  logic [SW-1:0]  chan;   // channel that produced y
  logic           valid;  // y/chan carry a fresh sample
  logic           wrap;   // last sample of a scan round

  modport master (
`ifdef MUXN_SCAN_MASK_EN
    output mask,
`endif
    output d, s, mode, en,
    input  y, chan, valid, wrap
  );

  modport slave (
`ifdef MUXN_SCAN_MASK_EN
    input  mask,
`endif
    input  d, s, mode, en,
    output y, chan, valid, wrap
  );
endinterface
`default_nettype wire

// File: rtl/muxn_scan.sv
`default_nettype none
// ============================================================================
// Module      : muxn_scan
// Description : Registered N-to-1 multiplexer with valid flag and auto-scan.
//               Direct mode picks channel s; scan mode steps an internal
//               pointer through the channels, holding each for DWELL
//               enabled cycles, and pulses wrap on the last sample of a round.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - muxn_scan_if.slave (d, s, mode, en, [mask] in;
//                       y, chan, valid, wrap out)
// Options     : MUXN_SCAN_MASK_EN - per-channel scan enable via bus.mask
// Revision    : 1.0 - initial release
// ============================================================================
module muxn_scan #(
  parameter int W     = 4,
  parameter int N     = 4,
  parameter int DWELL = 1
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  muxn_scan_if.slave   bus
);
  localparam int SW  = $clog2(N);
  localparam int DCW = $clog2(DWELL + 1);

  localparam logic [SW-1:0]  c_last_ch    = SW'(N - 1);
  localparam logic [DCW-1:0] c_dwell_last = DCW'(DWELL - 1);

  logic [W-1:0]   r_y;
  logic [SW-1:0]  r_chan;
  logic           r_valid;
  logic           r_wrap;
  logic [SW-1:0]  r_ptr;
  logic [DCW-1:0] r_dwell;

  logic [W-1:0]   w_ch [N];
  logic [N-1:0]   w_mask;
  logic           w_any;
  logic           w_s_ok;
  logic [SW-1:0]  w_next;
  logic [SW-1:0]  w_cand;
  logic           w_found;

  generate
    for (genvar k = 0; k < N; k++) begin : g_unpack
      assign w_ch[k] = bus.d[k*W +: W];
    end
  endgenerate

`ifdef MUXN_SCAN_MASK_EN
  assign w_mask = bus.mask;
`else
  // Without the mask feature every channel takes part in the scan.
  assign w_mask = '1;
`endif

  assign w_any  = |w_mask;
  // Extra bit so the compare also works when N is a power of two.
  assign w_s_ok = ({1'b0, bus.s} < (SW+1)'(N));

  // First enabled channel after r_ptr, searched circularly. With a single
  // enabled channel the search lands back on r_ptr itself.
  always_comb begin
    w_next  = r_ptr;
    w_cand  = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = (w_cand == c_last_ch) ? '0 : w_cand + SW'(1);
      if (!w_found && w_mask[w_cand]) begin
        w_next  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_ptr   <= '0;
      r_dwell <= '0;
    end else begin
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      if (!bus.mode) begin
        // Scan state is parked so a later scan always starts at channel 0.
        r_ptr   <= '0;
        r_dwell <= '0;
        if (bus.en) begin
          r_chan  <= bus.s;
          r_y     <= w_s_ok ? w_ch[bus.s] : '0;
          r_valid <= w_s_ok;
        end
      end else if (bus.en && w_any) begin
        if (!w_mask[r_ptr]) begin
          // Pointer sits on a disabled channel: skip without sampling.
          r_ptr   <= w_next;
          r_dwell <= '0;
        end else begin
          r_y     <= w_ch[r_ptr];
          r_chan  <= r_ptr;
          r_valid <= 1'b1;
          if (r_dwell == c_dwell_last) begin
            r_dwell <= '0;
            r_ptr   <= w_next;
            r_wrap  <= (w_next <= r_ptr);
          end else begin
            r_dwell <= r_dwell + DCW'(1);
          end
        end
      end
    end
  end

  assign bus.y     = r_y;
  assign bus.chan  = r_chan;
  assign bus.valid = r_valid;
  assign bus.wrap  = r_wrap;
endmodule
`default_nettype wire

// File: doc/muxn_scan.md
# muxn_scan

Parametrised registered N-to-1 multiplexer, the successor to the 2-input 4-bit mux. It adds a registered output with a valid flag and an auto-scan mode. In auto-scan mode an internal pointer steps through all channels, holding each for a programmable number of cycles. It sits between a bank of W-bit sources (register file ports, counters, switch inputs) and a single consumer such as a display driver or serial link that reads channels in time-division.

## Interface
- W, 4, data width per channel (≥1)
- N, 4, number of input channels (≥2)
- DWELL, 1, consecutive samples per channel in scan mode (≥1)
- SW (localparam), $clog2(N), select/pointer width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- d  input  N*W  flattened channel inputs; channel k = d[k*W +: W]
- s  input  SW  channel select, direct mode
- mode  input  1  0 = direct, 1 = auto-scan
- en  input  1  sample enable; no state advance when low
- mask  input  N  scan channel enable, bit k = channel k (present only with MUXN_SCAN_MASK_EN)
- y  output  W  registered selected data
- chan  output  SW  channel index that produced y
- valid  output  1  y/chan updated with a valid sample this cycle
- wrap  output  1  one-cycle pulse on the last sample of a scan round

## Operation
- Reset (reset=0, async): y=0, chan=0, valid=0, wrap=0, ptr=0, dwell_cnt=0.
- Internal state: ptr (SW bits), dwell_cnt ($clog2(DWELL+1) bits).
- Direct mode (mode=0):
  - en=1, s<N: y←d[s], chan←s, valid←1.
  - en=1, s≥N (non-power-of-2 N): y←0, chan←s, valid←0.
  - en=0: y and chan hold, valid←0.
  - wrap←0 always.
  - ptr←0 and dwell_cnt←0 every cycle, so scan always starts at channel 0.
- Scan mode (mode=1):
  - en=1: y←d[ptr], chan←ptr, valid←1.
  - If dwell_cnt==DWELL-1: dwell_cnt←0 and ptr←next channel. Otherwise dwell_cnt←dwell_cnt+1.
  - Next channel is (ptr+1) mod N. Wrap-around goes N-1 → 0.
  - wrap←1 in the same update in which ptr moves to a channel with index ≤ current ptr (the wrap point). Otherwise wrap←0.
  - en=0: ptr, dwell_cnt, y and chan frozen; valid←0, wrap←0.
  - s is ignored.
- Mode change: takes effect at the next rising edge. A 1→0 change mid-dwell discards the remaining dwell count.

## Timing
- Latency: 1 cycle from d/s/en to y/chan/valid. y samples d at the same edge that updates chan.
- Scan round length is N×DWELL enabled cycles (with the mask feature, popcount(mask)×DWELL). wrap is high exactly once per round.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-scan clears all state immediately, without waiting for a clock edge. The first edge after reset release in scan mode samples channel 0.

## Configuration
- MUXN_SCAN_MASK_EN defined:
  - The mask port exists.
  - In scan mode, next channel is the first index after ptr (circular) with mask=1. wrap follows the same ≤ rule.
  - If mask[ptr]=0 in an en cycle, no sample is taken: valid←0, y/chan hold, ptr←next enabled channel, dwell_cnt←0.
  - If mask is all zero: valid←0, wrap←0, ptr and dwell_cnt hold.
  - If exactly one bit is set, wrap pulses on every last dwell sample.
  - Direct mode ignores mask.
- MUXN_SCAN_MASK_EN undefined: no mask port; every channel is scanned in order 0..N-1.

## Test plan
- Reset: apply reset=0 with d nonzero and toggle clk → y=0, chan=0, valid=0, wrap=0. Release reset with mode=0, en=1, s=2, d={4'hD,4'hC,4'hB,4'hA} → next edge: y=4'hC, chan=2, valid=1.
- Direct mode: sweep s=0..3 with en=1, then en=0 → y=A,B,C,D one cycle after each s; with en=0, y holds 4'hD and valid=0.
- Scan, DWELL=2, N=4: mode=1, en=1 for 8 cycles → chan=0,0,1,1,2,2,3,3; wrap=1 only on the second chan=3 sample; the ninth sample has chan=0.
- Scan freeze: deassert en for 3 cycles after the first chan=1 sample → valid=0 and ptr frozen; on re-enable, the next sample is chan=1 (second dwell sample), then chan=2.
- Scan with mask (MUXN_SCAN_MASK_EN), DWELL=1, mask=4'b1010 → chan=1,3,1,3…, wrap on each chan=3. Then mask=0 → valid stays 0. Then mask=4'b0100 → chan=2 every cycle with wrap=1.
- Mid-scan reset: assert reset during a chan=2 sample → outputs clear immediately; after release, the first sample is chan=0.
